// File: rtl/refemv_memsys.sv
// refemv_memsys: memory/IO subsystem sitting behind the refemv core's memory port.
// Every access completes in fixed time; there is no stall path back to the core.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rstn       asynchronous active-low reset
//   mem_addr   byte address; bit 22 selects IO page (1) or RAM (0)
//   mem_wdata  write data, already byte-lane aligned
//   mem_wmask  byte write enables, nonzero means write
//   mem_rstrb  read strobe; mem_rdata is loaded on the strobed edge
//   mem_rdata  registered read data
//   leds       LED register
//   uart_tx    UART serial output, idle high
//
// IO page (byte offsets): 0x0 LEDS, 0x4 UART_DATA, 0x8 UART_STATUS, 0xC CYCLES.
// Optional build macro REFEMV_MEMSYS_CYCLES_EN adds a free-running cycle
// counter readable at 0xC; without it 0xC reads 0 and no counter exists.
module refemv_memsys #(
  parameter int unsigned RAM_AW  = 12,
  parameter int unsigned CLK_DIV = 104,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic [4:0]  leds,
  output logic        uart_tx
);

  localparam logic [15:0]  BAUD_LAST  = 16'(CLK_DIV - 1);
  localparam int unsigned  FIFO_DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  // Address decode
  logic              io_sel;
  logic [1:0]        io_reg;
  logic [RAM_AW-1:0] ram_idx;
  logic              led_we;
  logic              push_req;
  logic              ovf_clr;
  logic              ram_we;
  logic              unused_addr;

  assign io_sel      = mem_addr[22];
  assign io_reg      = mem_addr[3:2];
  assign ram_idx     = mem_addr[RAM_AW+1:2];
  assign led_we      = io_sel && (io_reg == 2'd0) && mem_wmask[0];
  assign push_req    = io_sel && (io_reg == 2'd1) && mem_wmask[0];
  assign ovf_clr     = io_sel && (io_reg == 2'd2) && mem_wmask[0] && mem_wdata[2];
  assign ram_we      = !io_sel && (|mem_wmask);
  // Upper/lower address bits are don't-care (RAM aliases, IO page mirrors).
  assign unused_addr = ^mem_addr;

  // RAM: contents are not reset
  logic [31:0] ram_q [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_wmask[i]) ram_q[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // UART FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= mem_wdata[7:0];
  end

  // Control registers and TX FSM state
  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ovf_q, ovf_d;
  logic [4:0]  leds_q, leds_d;
  logic [31:0] rdata_q;
  logic        baud_end;
  logic        busy;
  logic [31:0] cycles_val;
  logic [31:0] io_rdata;

  assign baud_end = (baud_q == BAUD_LAST);
  assign busy     = !empty || (state_q != S_IDLE);

`ifdef REFEMV_MEMSYS_CYCLES_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cyc_q <= '0;
    else       cyc_q <= cyc_q + 32'd1;
  end

  assign cycles_val = cyc_q;
`else
  assign cycles_val = '0;
`endif

  always_comb begin
    io_rdata = '0;
    case (io_reg)
      2'd0:    io_rdata = {27'b0, leds_q};
      2'd2:    io_rdata = {29'b0, ovf_q, busy, full};
      2'd3:    io_rdata = cycles_val;
      default: io_rdata = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    leds_d   = leds_q;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q[FIFO_AW-1:0]];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;

    // Set is applied after clear so a same-edge drop keeps overflow high.
    if (ovf_clr)               ovf_d = 1'b0;
    if (push_req && !push_ok)  ovf_d = 1'b1;

    if (led_we) leds_d = mem_wdata[4:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      leds_q   <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      leds_q   <= leds_d;
    end
  end

  // Read data sees pre-edge register/RAM values, giving read-before-write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          rdata_q <= '0;
    else if (mem_rstrb) rdata_q <= io_sel ? io_rdata : ram_q[ram_idx];
  end

  // Derived from state so reset forces the line idle without waiting for a clock.
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  assign mem_rdata = rdata_q;
  assign leds      = leds_q;

endmodule
